// File: rtl/ipm_pkg.sv
// ipm_pkg: register map, command bits and FSM encodings for the ipm_mc bridge
package ipm_pkg;
  localparam logic [3:0] ADDR_DATA0    = 4'h0;
  localparam logic [3:0] ADDR_DATA1    = 4'h1;
  localparam logic [3:0] ADDR_DATA2    = 4'h2;
  localparam logic [3:0] ADDR_DATA3    = 4'h3;
  localparam logic [3:0] ADDR_CONF     = 4'h4;
  localparam logic [3:0] ADDR_CHSEL    = 4'h5;
  localparam logic [3:0] ADDR_CMD      = 4'h6;
  localparam logic [3:0] ADDR_INT_PEND = 4'h7;
  localparam logic [3:0] ADDR_INT_MASK = 4'h8;
  localparam int CMD_WR = 0;
  localparam int CMD_RD = 1;
  localparam int CMD_ST = 2;
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, CAPTURE} state_t;
  typedef enum logic [1:0] {OP_WR, OP_RD, OP_ST} op_t;
endpackage

// File: rtl/ipm_sync_edge.sv
// ipm_sync_edge: SYNC-stage synchroniser producing a one-cycle pulse on a rising edge
module ipm_sync_edge #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic [SYNC-1:0] sr;
  logic prev;
  // shift the async level through the chain and keep the previous synced value
  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      prev <= 1'b0;
    end else begin
      sr   <= {sr[SYNC-2:0], d};
      prev <= sr[SYNC-1];
    end
  end
  assign rise = sr[SYNC-1] & ~prev;
endmodule

// File: rtl/ipm_mc.sv
// ipm_mc: MCU 8-bit async parallel bus to multi-channel AIP bridge
import ipm_pkg::*;
module ipm_mc #(
  parameter int IP_DW  = 32,
  parameter int NCH    = 4,
  parameter int CONF_W = 5,
  parameter int RD_LAT = 1,
  parameter int SYNC   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            mcu_addr_i,
  input  logic                  mcu_rd_i,
  input  logic                  mcu_wr_i,
  input  logic [7:0]            mcu_data_i,
  output logic [7:0]            mcu_data_o,
  output logic                  mcu_data_oe,
  output logic                  mcu_int_o,
  output logic [IP_DW-1:0]      ip_data_o,
  output logic [CONF_W-1:0]     ip_conf_o,
  input  logic [NCH*IP_DW-1:0]  ip_data_i,
  output logic [NCH-1:0]        ip_read_o,
  output logic [NCH-1:0]        ip_write_o,
  output logic [NCH-1:0]        ip_start_o,
  input  logic [NCH-1:0]        ip_int_i
);
  localparam int LANES = IP_DW / 8;
  localparam logic [3:0] NCH4   = 4'(NCH);
  localparam logic [2:0] CH_MAX = 3'(NCH - 1);
  localparam logic [2:0] LAST   = 3'(RD_LAT > 1 ? RD_LAT - 2 : 0);
  logic [SYNC-1:0][12:0] bus_sr;
  logic rd_s, rd_rise, wr_rise, rd_ok, wr_ok, busy, cmd_ok;
  logic [3:0] addr_s;
  logic [7:0] data_s, rd_mux;
  logic [31:0] rd32;
  logic [IP_DW-1:0] wdata, rdata;
  logic [CONF_W-1:0] conf;
  logic [2:0] chsel, cnt;
  logic [NCH-1:0] pend, mask, int_prev, onehot;
  state_t state, nxt;
  op_t op, cmd_op;
  // rd level travels with addr/data so the pad enable tracks the same synced view
  always_ff @(posedge clk)
    bus_sr <= rst ? '0 : {bus_sr[SYNC-2:0], {mcu_rd_i, mcu_addr_i, mcu_data_i}};
  assign {rd_s, addr_s, data_s} = bus_sr[SYNC-1];
  ipm_sync_edge #(.SYNC(SYNC)) u_rd (.clk(clk), .rst(rst), .d(mcu_rd_i), .rise(rd_rise));
  ipm_sync_edge #(.SYNC(SYNC)) u_wr (.clk(clk), .rst(rst), .d(mcu_wr_i), .rise(wr_rise));
  assign rd_ok  = rd_rise & ~wr_rise;
  assign wr_ok  = wr_rise & ~rd_rise;
  assign busy   = state != IDLE;
  assign cmd_ok = wr_ok && addr_s == ADDR_CMD && !busy && |data_s[2:0];
  assign cmd_op = data_s[CMD_RD] ? OP_RD : data_s[CMD_WR] ? OP_WR : OP_ST;
  assign mcu_data_oe = rd_s;
  assign ip_data_o   = wdata;
  assign ip_conf_o   = conf;
  assign rd32        = 32'(rdata);
  // shadow registers, command latch, wait counter and read capture
  always_ff @(posedge clk) begin
    if (rst) begin
      wdata <= '0;
      rdata <= '0;
      conf  <= '0;
      chsel <= '0;
      mask  <= '0;
      op    <= OP_WR;
      cnt   <= '0;
    end else begin
      for (int i = 0; i < LANES; i++)
        if (wr_ok && addr_s == 4'(i)) wdata[i*8 +: 8] <= data_s;
      if (wr_ok && addr_s == ADDR_CONF) conf <= data_s[CONF_W-1:0];
      if (wr_ok && addr_s == ADDR_CHSEL && !busy)
        chsel <= {1'b0, data_s[2:0]} >= NCH4 ? CH_MAX : data_s[2:0];
      if (wr_ok && addr_s == ADDR_INT_MASK) mask <= data_s[NCH-1:0];
      if (cmd_ok) op <= cmd_op;
      cnt <= state == RD_WAIT ? cnt + 3'd1 : '0;
      if (state == CAPTURE) rdata <= ip_data_i[chsel*IP_DW +: IP_DW];
    end
  end
  // edge-latched interrupts; a new edge wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      int_prev  <= '0;
      pend      <= '0;
      mcu_int_o <= 1'b0;
    end else begin
      int_prev  <= ip_int_i;
      pend      <= (pend & ~((wr_ok && addr_s == ADDR_INT_PEND) ? data_s[NCH-1:0] : '0)) | (ip_int_i & ~int_prev);
      mcu_int_o <= |(pend & mask);
    end
  end
  // register read mux
  always_comb
    rd_mux = addr_s <= ADDR_DATA3     ? rd32[addr_s[1:0]*8 +: 8] :
             addr_s == ADDR_CONF      ? 8'(conf) :
             addr_s == ADDR_CHSEL     ? {5'b0, chsel} :
             addr_s == ADDR_CMD       ? {7'b0, busy} :
             addr_s == ADDR_INT_PEND  ? 8'(pend) :
             addr_s == ADDR_INT_MASK  ? 8'(mask) : 8'h00;
  // MCU read data is frozen at the synced rd edge
  always_ff @(posedge clk)
    mcu_data_o <= rst ? 8'h00 : rd_ok ? rd_mux : mcu_data_o;
  // FSM state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  // FSM next state; RD_LAT of 1 goes straight to CAPTURE to keep exact latency
  always_comb
    nxt = state == IDLE    ? (cmd_ok ? ISSUE : IDLE) :
          state == ISSUE   ? (op == OP_RD ? (RD_LAT == 1 ? CAPTURE : RD_WAIT) : IDLE) :
          state == RD_WAIT ? (cnt == LAST ? CAPTURE : RD_WAIT) : IDLE;
  // one-hot strobes to the selected channel during ISSUE
  always_comb begin
    onehot     = NCH'(1) << chsel;
    ip_read_o  = state == ISSUE && op == OP_RD ? onehot : '0;
    ip_write_o = state == ISSUE && op == OP_WR ? onehot : '0;
    ip_start_o = state == ISSUE && op == OP_ST ? onehot : '0;
  end
endmodule

// File: tb/tb_ipm_mc.sv
// tb_ipm_mc: directed self-checking bench for ipm_mc (RD_LAT=3)
module tb_ipm_mc;
  logic clk, rst, mcu_rd_i, mcu_wr_i, mcu_data_oe, mcu_int_o;
  logic [3:0] mcu_addr_i, ip_read_o, ip_write_o, ip_start_o, ip_int_i;
  logic [7:0] mcu_data_i, mcu_data_o, v;
  logic [31:0] ip_data_o, ch1;
  logic [4:0] ip_conf_o;
  logic [127:0] ip_data_i;
  int n_cmp = 0, n_bad = 0, cyc = 0, rd_at = -100, rd_n = 0, wr_n = 0, st_n = 0, b_rd, b_wr;
  logic [3:0] rd_v, wr_v;
  logic [31:0] wr_d;
  logic [4:0] wr_c;
  ipm_mc #(.IP_DW(32), .NCH(4), .CONF_W(5), .RD_LAT(3), .SYNC(2)) dut (
    .clk(clk), .rst(rst), .mcu_addr_i(mcu_addr_i), .mcu_rd_i(mcu_rd_i), .mcu_wr_i(mcu_wr_i),
    .mcu_data_i(mcu_data_i), .mcu_data_o(mcu_data_o), .mcu_data_oe(mcu_data_oe), .mcu_int_o(mcu_int_o),
    .ip_data_o(ip_data_o), .ip_conf_o(ip_conf_o), .ip_data_i(ip_data_i), .ip_read_o(ip_read_o),
    .ip_write_o(ip_write_o), .ip_start_o(ip_start_o), .ip_int_i(ip_int_i));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // ch1 shows the good word only in the cycle exactly 3 after the read pulse
  assign ch1 = (cyc == rd_at + 3) ? 32'hCAFEBABE : 32'h11111111;
  assign ip_data_i = {32'h33333333, 32'h22222222, ch1, 32'hA5A5A5A5};
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ip_read_o != 0) begin rd_n++; rd_v = ip_read_o; rd_at = cyc; end
    if (ip_write_o != 0) begin wr_n++; wr_v = ip_write_o; wr_d = ip_data_o; wr_c = ip_conf_o; end
    if (ip_start_o != 0) st_n++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic mcu_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    mcu_addr_i = a; mcu_data_i = d; mcu_wr_i = 1'b1;
    repeat (4) @(negedge clk);
    mcu_wr_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic mcu_rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    @(negedge clk);
    mcu_addr_i = a; mcu_rd_i = 1'b1;
    repeat (4) @(negedge clk);
    chk(tag, mcu_data_o, exp);
    mcu_rd_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; mcu_rd_i = 0; mcu_wr_i = 0; mcu_addr_i = 0; mcu_data_i = 0; ip_int_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {mcu_data_o, mcu_data_oe, mcu_int_o, ip_read_o, ip_write_o, ip_start_o}, 0);
    chk("rst_bus", {ip_data_o, 27'd0, ip_conf_o}, 0);
    rst = 1'b0;
    mcu_rd("rst_status", 4'h6, 8'h00);
    chk("oe_low", mcu_data_oe, 0);
    mcu_wr(4'h0, 8'h78); mcu_wr(4'h1, 8'h56); mcu_wr(4'h2, 8'h34); mcu_wr(4'h3, 8'h12);
    mcu_wr(4'h4, 8'h03); mcu_wr(4'h5, 8'h02); mcu_wr(4'h6, 8'h01);
    repeat (4) @(negedge clk);
    chk("wr_count", wr_n, 1);
    chk("wr_onehot", wr_v, 4'b0100);
    chk("wr_data", wr_d, 32'h12345678);
    chk("wr_conf", wr_c, 5'h03);
    chk("no_rd_st", rd_n + st_n, 0);
    mcu_wr(4'h5, 8'h07);
    mcu_rd("chsel_sat", 4'h5, 8'h03);
    mcu_wr(4'h5, 8'h01);
    mcu_wr(4'h6, 8'h02);
    repeat (4) @(negedge clk);
    chk("rd_count", rd_n, 1);
    chk("rd_onehot", rd_v, 4'b0010);
    mcu_rd("rdata0", 4'h0, 8'hBE);
    mcu_rd("rdata1", 4'h1, 8'hBA);
    mcu_rd("rdata2", 4'h2, 8'hFE);
    mcu_rd("rdata3", 4'h3, 8'hCA);
    mcu_rd("addr9", 4'h9, 8'h00);
    b_rd = rd_n; b_wr = wr_n;
    @(negedge clk); mcu_addr_i = 4'h6; mcu_data_i = 8'h02; mcu_wr_i = 1'b1;
    @(negedge clk); mcu_wr_i = 1'b0;
    @(negedge clk); mcu_data_i = 8'h01; mcu_wr_i = 1'b1;
    @(negedge clk); mcu_wr_i = 1'b0; mcu_rd_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("busy_status", mcu_data_o, 8'h01);
    mcu_rd_i = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy_no_wr", wr_n - b_wr, 0);
    chk("busy_one_rd", rd_n - b_rd, 1);
    mcu_rd("idle_status", 4'h6, 8'h00);
    mcu_wr(4'h8, 8'h05);
    ip_int_i = 4'b0100;
    repeat (4) @(negedge clk);
    mcu_rd("pend_2", 4'h7, 8'h04);
    chk("int_on", mcu_int_o, 1);
    mcu_wr(4'h7, 8'h04);
    repeat (3) @(negedge clk);
    chk("int_cleared", mcu_int_o, 0);
    mcu_rd("pend_clr", 4'h7, 8'h00);
    ip_int_i = 4'b0110;
    repeat (4) @(negedge clk);
    mcu_rd("pend_1", 4'h7, 8'h02);
    chk("int_masked", mcu_int_o, 0);
    mcu_rd("mask_rd", 4'h8, 8'h05);
    @(negedge clk); mcu_addr_i = 4'h4; mcu_data_i = 8'h1F; mcu_rd_i = 1'b1; mcu_wr_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("simul_no_rd", mcu_data_o, 8'h05);
    mcu_rd_i = 1'b0; mcu_wr_i = 1'b0;
    repeat (4) @(negedge clk);
    mcu_rd("simul_conf", 4'h4, 8'h03);
    ip_int_i = 4'b0000;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b_rd = rd_n;
    @(negedge clk); mcu_addr_i = 4'h6; mcu_data_i = 8'h02; mcu_wr_i = 1'b1;
    @(negedge clk); mcu_wr_i = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_mid_outs", {mcu_data_o, mcu_int_o, ip_read_o, ip_write_o, ip_start_o}, 0);
    chk("rst_mid_pulse", rd_n - b_rd, 1);
    repeat (6) @(negedge clk);
    mcu_rd("rst_mid_idle", 4'h6, 8'h00);
    mcu_rd("rst_mid_rdata", 4'h0, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
